opcode_sequencer: RTL and testbench
===================================

// Module: opcode_sequencer
// PURPOSE
//  Decode-stage sequencer directly upstream of the control unit: turns the fetched 5-bit opcode
//  into the per-cycle opcode that the control unit consumes. Splits CALL/RET/RTI into two-part
//  sequences, injects the two-part interrupt sequence, and inserts load-use bubbles.
//  Freezes PC and IF/ID through pcStall while a sequence is in progress.
// PARAMETERS
//  CNT_W  16  width of the optional statistics counters
// PORTS
//  clk             in   1      clock; all state updates on the rising edge
//  rst             in   1      asynchronous, active-low reset
//  instrOpCode     in   5      opcode from the IF/ID register
//  instrValid      in   1      IF/ID holds a real instruction
//  interrupt       in   1      external interrupt request, synchronous to clk
//  loadUseHazard   in   1      load-use hazard flag from the hazard unit
//  flush           in   1      taken branch in a later stage; discard the current decode-stage op
//  opCode          out  5      opcode to the control unit
//  makeMeBubble    out  1      bubble request to the control unit
//  pcStall         out  1      hold PC and IF/ID this cycle
//  intAck          out  1      one-cycle acknowledge, registered
//  bubbleCount     out  CNT_W  only with SEQ_STATS_EN
//  expandCount     out  CNT_W  only with SEQ_STATS_EN
// BEHAVIOUR
//  - State register: NORMAL, SECOND, INT1, INT2. Second-part register pend[4:0] and intPending.
//  - opCode, makeMeBubble and pcStall are combinational from state and inputs, with zero-cycle
//    latency. intAck is registered.
//  - Reset (rst=0, asynchronous): state=NORMAL, pend=00000, intPending=0, intAck=0, counters=0.
//    Combinational outputs then read opCode=00000, makeMeBubble=0, pcStall=0.
//  - intPending is set on a rising edge of interrupt (prev-sample register).
//    - Edges are ignored while intPending=1 or state is INT1/INT2.
//    - intPending is cleared when INT1 is entered.
//  - NORMAL, priority high to low:
//    1. flush: opCode=00000, no stall, stay in NORMAL.
//    2. intPending: opCode=11110, pcStall=1, go to INT1.
//    3. instrValid=0: opCode=00000.
//    4. loadUseHazard: makeMeBubble=1, opCode=00000, pcStall=1, stay in NORMAL.
//    5. Reserved input opcode 11001/11011/11101/11110/11111: opCode=00000, no stall.
//    6. 11000/11010/11100: pass the opcode through, pcStall=1, pend=opcode+1, go to SECOND.
//    7. Otherwise: pass instrOpCode through, no stall.
//  - SECOND:
//    - flush: opCode=00000, pend is dropped, go to NORMAL.
//    - Else: opCode=pend, pcStall=0, go to NORMAL.
//    - loadUseHazard is ignored in this state.
//  - INT1: opCode=11110, pcStall=1, go to INT2. flush and hazard are ignored.
//  - INT2: opCode=11111, pcStall=1, go to NORMAL; intAck=1 on the following cycle.
//    The held IF/ID instruction is re-presented afterwards and is not lost.
//  - flush and interrupt in the same cycle: flush wins; the interrupt stays pending and is
//    taken on the next NORMAL cycle.
//  - makeMeBubble is never asserted outside NORMAL.
// CONFIGURATION
//  - SEQ_STATS_EN defined:
//    - bubbleCount increments on each cycle with makeMeBubble=1.
//    - expandCount increments on each entry to SECOND.
//    - Both saturate at 2^CNT_W-1 and clear on reset.
//  - SEQ_STATS_EN undefined: both ports and their counters are absent. No other behaviour changes.
// TESTING
//  - CALL expansion:
//    - Stimulus: instrOpCode=11000, valid.
//    - Response: cycle0 opCode=11000 pcStall=1; cycle1 opCode=11001 pcStall=0; cycle2 next instr.
//  - Load-use bubble:
//    - Stimulus: 01001 valid with loadUseHazard=1 for 1 cycle.
//    - Response: opCode=00000 makeMeBubble=1 pcStall=1; next cycle opCode=01001 makeMeBubble=0.
//  - Interrupt:
//    - Stimulus: 1-cycle interrupt pulse while 01001 is held.
//    - Response: 11110 (pcStall=1), then 11111 (pcStall=1), then intAck=1 with opCode=01001.
//  - Flush in SECOND:
//    - Stimulus: RET, then flush=1 on the second cycle.
//    - Response: opCode=00000; 11011 is never emitted; state NORMAL.
//  - Reserved input:
//    - Stimulus: instrOpCode=11101, valid.
//    - Response: opCode=00000, pcStall=0.
//  - Reset during INT1:
//    - Stimulus: rst=0 asynchronously.
//    - Response: opCode=00000, pcStall=0, intAck=0 at once; after release, no 11111 is emitted.

Source files
------------

// File: rtl/opcode_sequencer.sv
// Decode-stage opcode sequencer: expands CALL/RET/RTI, injects the interrupt pair, inserts load-use bubbles.
// Optional saturating statistics counters are enabled with `define SEQ_STATS_EN.
module opcode_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       instrOpCode,
  input  logic             instrValid,
  input  logic             interrupt,
  input  logic             loadUseHazard,
  input  logic             flush,
  output logic [4:0]       opCode,
  output logic             makeMeBubble,
  output logic             pcStall,
  output logic             intAck
`ifdef SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] bubbleCount,
  output logic [CNT_W-1:0] expandCount
`endif
);

  // state  | meaning
  // NORMAL | single-cycle decode, hazards and interrupt entry
  // SECOND | emitting the second half of CALL/RET/RTI from pend
  // INT1   | first interrupt opcode repeated, fetch held
  // INT2   | second interrupt opcode, intAck follows
  typedef enum logic [1:0] {NORMAL, SECOND, INT1, INT2} seqState_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_INT1 = 5'b11110;
  localparam logic [4:0] OP_INT2 = 5'b11111;

  seqState_t  state, nextState;
  logic [4:0] pend;
  logic       intPending, intPrev;
  logic [4:0] opNext;
  logic       bubbleNext, stallNext, loadPend;
  logic       isReserved, isExpand, intEdge;

  always_comb begin
    isReserved = (instrOpCode == 5'b11001) || (instrOpCode == 5'b11011) ||
                 (instrOpCode == 5'b11101) || (instrOpCode == 5'b11110) ||
                 (instrOpCode == 5'b11111);
    isExpand   = (instrOpCode == 5'b11000) || (instrOpCode == 5'b11010) ||
                 (instrOpCode == 5'b11100);
  end

  always_comb begin
    opNext     = OP_NOP;
    bubbleNext = 1'b0;
    stallNext  = 1'b0;
    loadPend   = 1'b0;
    nextState  = state;
    case (state)
      NORMAL: begin
        if (flush) begin
          opNext = OP_NOP;
        end else if (intPending) begin
          opNext    = OP_INT1;
          stallNext = 1'b1;
          nextState = INT1;
        end else if (!instrValid) begin
          opNext = OP_NOP;
        end else if (loadUseHazard) begin
          bubbleNext = 1'b1;
          stallNext  = 1'b1;
        end else if (isReserved) begin
          opNext = OP_NOP;
        end else if (isExpand) begin
          opNext    = instrOpCode;
          stallNext = 1'b1;
          loadPend  = 1'b1;
          nextState = SECOND;
        end else begin
          opNext = instrOpCode;
        end
      end
      SECOND: begin
        opNext    = flush ? OP_NOP : pend;
        nextState = NORMAL;
      end
      INT1: begin
        opNext    = OP_INT1;
        stallNext = 1'b1;
        nextState = INT2;
      end
      default: begin
        opNext    = OP_INT2;
        stallNext = 1'b1;
        nextState = NORMAL;
      end
    endcase
  end

  // Outputs are forced idle while reset is held so they drop immediately on assertion.
  assign opCode       = rst ? opNext : OP_NOP;
  assign makeMeBubble = rst & bubbleNext;
  assign pcStall      = rst & stallNext;

  assign intEdge = interrupt & ~intPrev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= NORMAL;
      pend       <= 5'b00000;
      intPending <= 1'b0;
      intPrev    <= 1'b0;
      intAck     <= 1'b0;
    end else begin
      state   <= nextState;
      intPrev <= interrupt;
      intAck  <= (state == INT2);
      if (loadPend)
        pend <= instrOpCode + 5'd1;
      else if (state == SECOND)
        pend <= 5'b00000;
      if (state == NORMAL && nextState == INT1)
        intPending <= 1'b0;
      else if (intEdge && state != INT1 && state != INT2)
        intPending <= 1'b1;
    end
  end

`ifdef SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubbleCount <= '0;
      expandCount <= '0;
    end else begin
      if (bubbleNext && bubbleCount != {CNT_W{1'b1}})
        bubbleCount <= bubbleCount + 1'b1;
      if (loadPend && expandCount != {CNT_W{1'b1}})
        expandCount <= expandCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer: expansion, bubbles, flush, reserved opcodes, interrupts, reset.
module tb_opcode_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       instrOpCode;
  logic             instrValid, interrupt, loadUseHazard, flush;
  logic [4:0]       opCode;
  logic             makeMeBubble, pcStall, intAck;
`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0] bubbleCount, expandCount;
`endif

  int total = 0;
  int bad   = 0;

  opcode_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instrOpCode(instrOpCode), .instrValid(instrValid),
    .interrupt(interrupt), .loadUseHazard(loadUseHazard), .flush(flush),
    .opCode(opCode), .makeMeBubble(makeMeBubble), .pcStall(pcStall), .intAck(intAck)
`ifdef SEQ_STATS_EN
    , .bubbleCount(bubbleCount), .expandCount(expandCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic [4:0] op, input logic bub,
                        input logic stall, input logic ack);
    chk({tag, ".opCode"}, {27'd0, opCode}, {27'd0, op});
    chk({tag, ".bubble"}, {31'd0, makeMeBubble}, {31'd0, bub});
    chk({tag, ".pcStall"}, {31'd0, pcStall}, {31'd0, stall});
    chk({tag, ".intAck"}, {31'd0, intAck}, {31'd0, ack});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic v, input logic haz,
                       input logic fl, input logic irq);
    instrOpCode = op; instrValid = v; loadUseHazard = haz; flush = fl; interrupt = irq;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    instrOpCode = 5'b01001; instrValid = 1'b1;
    interrupt = 1'b0; loadUseHazard = 1'b0; flush = 1'b0;
    #3;
    chkOut("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
    #4 rst = 1'b1;
    step();

    drive(5'b00101, 1, 0, 0, 0); chkOut("pass", 5'b00101, 0, 0, 0); step();

    drive(5'b11000, 1, 0, 0, 0); chkOut("call0", 5'b11000, 0, 1, 0); step();
    chkOut("call1", 5'b11001, 0, 0, 0); step();
    drive(5'b00011, 1, 0, 0, 0); chkOut("call2", 5'b00011, 0, 0, 0); step();

    drive(5'b11100, 1, 0, 0, 0); chkOut("rti0", 5'b11100, 0, 1, 0); step();
    chkOut("rti1", 5'b11101, 0, 0, 0); step();

    drive(5'b01001, 1, 1, 0, 0); chkOut("luse0", 5'b00000, 1, 1, 0); step();
    drive(5'b01001, 1, 0, 0, 0); chkOut("luse1", 5'b01001, 0, 0, 0); step();

    drive(5'b11010, 1, 0, 0, 0); chkOut("retHaz0", 5'b11010, 0, 1, 0); step();
    drive(5'b11010, 1, 1, 0, 0); chkOut("retHaz1", 5'b11011, 0, 0, 0); step();

    drive(5'b11010, 1, 0, 0, 0); chkOut("retFl0", 5'b11010, 0, 1, 0); step();
    drive(5'b11010, 1, 0, 1, 0); chkOut("retFl1", 5'b00000, 0, 0, 0); step();
    drive(5'b00111, 1, 0, 0, 0); chkOut("retFl2", 5'b00111, 0, 0, 0); step();

    drive(5'b11101, 1, 0, 0, 0); chkOut("rsv11101", 5'b00000, 0, 0, 0); step();
    drive(5'b11111, 1, 0, 0, 0); chkOut("rsv11111", 5'b00000, 0, 0, 0); step();
    drive(5'b11001, 1, 0, 0, 0); chkOut("rsv11001", 5'b00000, 0, 0, 0); step();

    drive(5'b11000, 0, 0, 0, 0); chkOut("invalid", 5'b00000, 0, 0, 0); step();
    drive(5'b00001, 1, 0, 0, 0); chkOut("afterInv", 5'b00001, 0, 0, 0); step();

    drive(5'b11000, 1, 0, 1, 0); chkOut("flushN", 5'b00000, 0, 0, 0); step();
    drive(5'b00010, 1, 0, 0, 0); chkOut("afterFl", 5'b00010, 0, 0, 0); step();

`ifdef SEQ_STATS_EN
    chk("bubbleCount", {16'd0, bubbleCount}, 32'd1);
    chk("expandCount", {16'd0, expandCount}, 32'd4);
`endif

    drive(5'b01001, 1, 0, 0, 1); chkOut("int0", 5'b01001, 0, 0, 0); step();
    drive(5'b01001, 1, 0, 0, 0); chkOut("int1", 5'b11110, 0, 1, 0); step();
    drive(5'b01001, 1, 1, 1, 1); chkOut("int2", 5'b11110, 0, 1, 0); step();
    drive(5'b01001, 1, 0, 0, 0); chkOut("int3", 5'b11111, 0, 1, 0); step();
    chkOut("intAck", 5'b01001, 0, 0, 1); step();
    chkOut("intDone", 5'b01001, 0, 0, 0); step();

    drive(5'b01001, 1, 0, 1, 1); chkOut("flInt0", 5'b00000, 0, 0, 0); step();
    drive(5'b01001, 1, 0, 1, 0); chkOut("flInt1", 5'b00000, 0, 0, 0); step();
    drive(5'b01001, 1, 0, 0, 0); chkOut("flInt2", 5'b11110, 0, 1, 0); step();
    chkOut("flInt3", 5'b11110, 0, 1, 0); step();
    chkOut("flInt4", 5'b11111, 0, 1, 0); step();
    chkOut("flInt5", 5'b01001, 0, 0, 1); step();

    drive(5'b01001, 1, 0, 0, 1); step();
    drive(5'b01001, 1, 0, 0, 0); step();
    chkOut("rstInt1", 5'b11110, 0, 1, 0);
    #1 rst = 1'b0;
    #1 chkOut("rstAsync", 5'b00000, 0, 0, 0);
    step();
    rst = 1'b1;
    #1 chkOut("rstRel0", 5'b01001, 0, 0, 0);
    step();
    chkOut("rstRel1", 5'b01001, 0, 0, 0);
`ifdef SEQ_STATS_EN
    chk("bubbleCountRst", {16'd0, bubbleCount}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
